// File: rtl/icache_fill_ctrl.sv
// I-cache fill sequencer: one fetch request at a time, lookup, DRAM miss fill, bypass response.
// Optional hit/miss performance counters are built when ICACHE_FILL_PERF_EN is defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ICACHE_DATA_BLOCK_SIZE
`define ICACHE_DATA_BLOCK_SIZE 64
`endif

module icache_fill_ctrl #(
    parameter int ADDR_W     = `ADDR_WIDTH,
    parameter int BLOCK_BITS = `ICACHE_DATA_BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [BLOCK_BITS-1:0] resp_data,
    output logic [ADDR_W-1:0]     cache_addr,
    output logic                  cache_we_aL,
    output logic [BLOCK_BITS-1:0] cache_wdata,
    input  logic [BLOCK_BITS-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  dram_req_valid,
    input  logic                  dram_req_ready,
    output logic [ADDR_W-1:0]     dram_req_addr,
    input  logic                  dram_resp_valid,
    input  logic [BLOCK_BITS-1:0] dram_resp_data
`ifdef ICACHE_FILL_PERF_EN
    ,
    output logic [31:0]           perf_hits,
    output logic [31:0]           perf_misses
`endif
);

    localparam int OFF_BITS = $clog2(BLOCK_BITS / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_FILL
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [BLOCK_BITS-1:0] r_fill;
    logic                  r_kill;

    logic w_lookup_resp;
    logic w_fill_resp;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_fill  <= '0;
            r_kill  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        r_addr  <= req_addr;
                        r_kill  <= 1'b0;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (flush || cache_hit) r_state <= S_IDLE;
                    else                    r_state <= S_MISS_REQ;
                end
                S_MISS_REQ: begin
                    if (flush)          r_kill  <= 1'b1;
                    if (dram_req_ready) r_state <= S_MISS_WAIT;
                end
                S_MISS_WAIT: begin
                    if (flush) r_kill <= 1'b1;
                    if (dram_resp_valid) begin
                        r_fill  <= dram_resp_data;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    // The fill always completes; a flush here only suppresses the response.
                    if (flush) r_kill <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_lookup_resp = (r_state == S_LOOKUP) && cache_hit && !r_kill && !flush;
    assign w_fill_resp   = (r_state == S_FILL) && !r_kill && !flush;

    assign req_ready      = (r_state == S_IDLE);
    assign resp_valid     = w_lookup_resp || w_fill_resp;
    assign resp_data      = w_lookup_resp ? cache_rdata :
                            w_fill_resp   ? r_fill      : '0;
    // Present the incoming address while idle so the SRAM read overlaps the accept cycle.
    assign cache_addr     = (r_state == S_IDLE) ? req_addr : r_addr;
    assign cache_we_aL    = (r_state != S_FILL);
    assign cache_wdata    = r_fill;
    assign dram_req_valid = (r_state == S_MISS_REQ);
    assign dram_req_addr  = {r_addr[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};

`ifdef ICACHE_FILL_PERF_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (cache_hit) r_perf_hits   <= r_perf_hits + 32'd1;
            else           r_perf_misses <= r_perf_misses + 32'd1;
        end
    end

    assign perf_hits   = r_perf_hits;
    assign perf_misses = r_perf_misses;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: behavioural cache and scripted DRAM, response scoreboard.
`timescale 1ns/1ps
module tb_icache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_aL = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [31:0] cache_addr;
    logic        cache_we_aL;
    logic [63:0] cache_wdata;
    logic [63:0] cache_rdata;
    logic        cache_hit;
    logic        dram_req_valid;
    logic        dram_req_ready = 1'b0;
    logic [31:0] dram_req_addr;
    logic        dram_resp_valid = 1'b0;
    logic [63:0] dram_resp_data = '0;
`ifdef ICACHE_FILL_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    int n_checks = 0;
    int n_pass = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mem [int unsigned];

    icache_fill_ctrl dut (
        .clk(clk), .rst_aL(rst_aL),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush), .resp_valid(resp_valid), .resp_data(resp_data),
        .cache_addr(cache_addr), .cache_we_aL(cache_we_aL), .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
        .dram_req_addr(dram_req_addr), .dram_resp_valid(dram_resp_valid),
        .dram_resp_data(dram_resp_data)
`ifdef ICACHE_FILL_PERF_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Cache model: hit/data valid one cycle after the address, write when we_aL is low.
    always @(posedge clk) begin
        int unsigned key;
        key = cache_addr >> 3;
        cache_hit   <= mem.exists(key);
        cache_rdata <= mem.exists(key) ? mem[key] : 64'h0;
        if (!cache_we_aL) mem[key] = cache_wdata;
    end

    // Scoreboard: every response must match the oldest expected block.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_aL && resp_valid) begin
            if (exp_q.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                check("resp_data", resp_data, e);
            end
        end
    end

    task automatic hit_req(input logic [31:0] addr, input logic [63:0] data, input bit flush_lookup);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = addr;
        @(negedge clk) check("hit_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_hits++;
        if (flush_lookup) flush = 1'b1;
        else exp_q.push_back(data);
        @(negedge clk);
        check("hit_no_dram", dram_req_valid, 1'b0);
        check("hit_resp_valid", resp_valid, !flush_lookup);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk) check("hit_back_idle", req_ready, 1'b1);
    endtask

    // mode 0: normal, 1: flush in MISS_WAIT, 2: reset in MISS_WAIT
    task automatic miss_req(input logic [31:0] addr, input logic [63:0] data,
                            input int rdy_dly, input int rsp_dly, input int mode);
        logic [31:0] blk;
        blk = addr & ~32'h7;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = addr;
        @(negedge clk) check("miss_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_misses++;
        @(negedge clk) check("miss_no_resp", resp_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("dram_req_valid", dram_req_valid, 1'b1);
        check("dram_req_addr", dram_req_addr, blk);
        check("miss_busy", req_ready, 1'b0);
        for (int i = 0; i < rdy_dly; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_valid_held", dram_req_valid, 1'b1);
            check("bp_addr_held", dram_req_addr, blk);
            check("bp_busy", req_ready, 1'b0);
        end
        @(posedge clk); #1 dram_req_ready = 1'b1;
        @(posedge clk); #1 dram_req_ready = 1'b0;
        @(negedge clk) check("wait_req_dropped", dram_req_valid, 1'b0);
        if (mode == 2) begin
            #1 rst_aL = 1'b0;
            #1;
            check("rst_req_ready", req_ready, 1'b1);
            check("rst_we_aL", cache_we_aL, 1'b1);
            check("rst_dram_valid", dram_req_valid, 1'b0);
            exp_hits = 0; exp_misses = 0;
            @(posedge clk); #1 rst_aL = 1'b1;
            dram_resp_valid = 1'b1; dram_resp_data = data;
            @(posedge clk); #1 dram_resp_valid = 1'b0;
            @(negedge clk);
            check("late_beat_no_fill", cache_we_aL, 1'b1);
            check("late_beat_idle", req_ready, 1'b1);
            return;
        end
        if (mode == 1) flush = 1'b1;
        for (int i = 0; i < rsp_dly; i++) begin
            @(posedge clk); #1 flush = 1'b0;
        end
        dram_resp_valid = 1'b1; dram_resp_data = data;
        if (mode != 1) exp_q.push_back(data);
        @(posedge clk); #1;
        dram_resp_valid = 1'b0; dram_resp_data = {$urandom, $urandom};
        @(negedge clk);
        check("fill_we_aL", cache_we_aL, 1'b0);
        check("fill_wdata", cache_wdata, data);
        check("fill_addr", cache_addr, addr);
        check("fill_resp_valid", resp_valid, mode != 1);
        check("fill_busy", req_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_fill_we_aL", cache_we_aL, 1'b1);
        check("post_fill_idle", req_ready, 1'b1);
        check("post_fill_resp", resp_valid, 1'b0);
    endtask

    initial begin
        logic [63:0] rdata [4];
        logic [31:0] raddr [4];
        logic [63:0] blk40;

        #12;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_resp_data", resp_data, 64'h0);
        check("reset_we_aL", cache_we_aL, 1'b1);
        check("reset_dram_valid", dram_req_valid, 1'b0);
        @(posedge clk); #1 rst_aL = 1'b1;

        // Reset mid-miss, then the same block must still miss.
        miss_req(32'h4000, 64'h1111_2222_3333_4444, 0, 2, 2);
        miss_req(32'h4000, 64'h5555_6666_7777_8888, 0, 1, 0);

        blk40 = {$urandom, $urandom};
        miss_req(32'h40, blk40, 0, 2, 0);
        hit_req(32'h44, blk40, 1'b0);

        miss_req(32'h1008, 64'hDEAD_BEEF_CAFE_F00D, 0, 3, 0);
        hit_req(32'h1008, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);

        miss_req(32'h2014, 64'h0123_4567_89AB_CDEF, 5, 2, 0);

        hit_req(32'h40, blk40, 1'b1);

        @(posedge clk); #1;
        req_valid = 1'b1; flush = 1'b1; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_blocked", req_ready, 1'b1);
        check("flush_idle_no_resp", resp_valid, 1'b0);

        miss_req(32'h3000, 64'hA5A5_5A5A_0F0F_F0F0, 0, 3, 1);
        hit_req(32'h3000, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            raddr[i] = 32'h8000 + 32'(i * 8) + 32'($urandom_range(0, 7));
            rdata[i] = {$urandom, $urandom};
            miss_req(raddr[i], rdata[i], $urandom_range(0, 3), $urandom_range(1, 4), 0);
        end
        for (int i = 0; i < 4; i++) hit_req(raddr[i] ^ 32'($urandom_range(0, 7)), rdata[i], 1'b0);

`ifdef ICACHE_FILL_PERF_EN
        @(negedge clk);
        check("perf_hits", perf_hits, 64'(exp_hits));
        check("perf_misses", perf_misses, 64'(exp_misses));
        @(posedge clk); #1 dut.r_perf_misses = 32'hFFFF_FFFF;
        miss_req(32'h9000, 64'h0BAD_F00D_0BAD_F00D, 0, 1, 0);
        check("perf_miss_wrap", perf_misses, 64'h0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
